// File: rtl/fp_rshift_pipe_if.sv
// fp_rshift_pipe_if: handshake bundle for the alignment shifter.
//   in_valid/in_ready/val/count/tag_i   : item entering the shifter
//   out_valid/out_ready/val_o/guard_o/round_o/sticky_o/tag_o : aligned result
//   slave modport is the shifter side, master modport the producer/consumer side
interface fp_rshift_pipe_if #(
   parameter int SHIFTWIDTH = 5,
   parameter int DATAWIDTH  = 24,
   parameter int TAGWIDTH   = 9
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATAWIDTH-1:0]  val;
   logic [SHIFTWIDTH-1:0] count;
   logic [TAGWIDTH-1:0]   tag_i;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATAWIDTH-1:0]  val_o;
   logic                  guard_o;
   logic                  round_o;
   logic                  sticky_o;
   logic [TAGWIDTH-1:0]   tag_o;
   modport slave (
      input  in_valid, val, count, tag_i, out_ready,
      output in_ready, out_valid, val_o, guard_o, round_o, sticky_o, tag_o
   );
   modport master (
      output in_valid, val, count, tag_i, out_ready,
      input  in_ready, out_valid, val_o, guard_o, round_o, sticky_o, tag_o
   );
endinterface

// File: rtl/fp_rshift_pipe.sv
// fp_rshift_pipe: pipelined right shifter aligning a mantissa, with guard/round/sticky.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fp_rshift_pipe_if.slave (input item + count + tag, output result + GRS + tag)
module fp_rshift_pipe #(
   parameter int SHIFTWIDTH = 5,
   parameter int DATAWIDTH  = 24,
   parameter int TAGWIDTH   = 9
) (
   input logic clk,
   input logic rst,
   fp_rshift_pipe_if.slave bus
);
   localparam int W = DATAWIDTH + 2;
   localparam int N = SHIFTWIDTH;
   for (genvar k = 0; k < N; k++) begin : stg
      localparam int A = 1 << k;
      // mask of the bits this stage can push out; all ones once 2^k reaches W
      localparam logic [W-1:0] M = ~({W{1'b1}} << A);
      logic                v, ld, s;
      logic [W-1:0]        d;
      logic [TAGWIDTH-1:0] t;
      logic                vi, si;
      logic [W-1:0]        di;
      logic [TAGWIDTH-1:0] ti;
      // remaining count bits; bit 0 is this stage's shift enable
      logic [N-k-1:0]      ci;
      if (k == 0) begin : src
         assign vi = bus.in_valid;
         assign di = {bus.val, 2'b00};
         assign si = 1'b0;
         assign ci = bus.count;
         assign ti = bus.tag_i;
      end else begin : src
         assign vi = stg[k-1].v;
         assign di = stg[k-1].d;
         assign si = stg[k-1].s;
         assign ci = stg[k-1].cr.c;
         assign ti = stg[k-1].t;
      end
      if (k == N - 1) begin : rdy
         assign ld = !v || bus.out_ready;
      end else begin : rdy
         assign ld = !v || stg[k+1].ld;
      end
      always_ff @(posedge clk)
         if (rst) begin
            v <= 1'b0;
            d <= '0;
            s <= 1'b0;
            t <= '0;
         end else if (ld) begin
            v <= vi;
            if (vi) begin
               d <= ci[0] ? di >> A : di;
               s <= si | (ci[0] & |(di & M));
               t <= ti;
            end
         end
      if (k < N - 1) begin : cr
         logic [N-k-2:0] c;
         always_ff @(posedge clk)
            if (rst) c <= '0;
            else if (ld && vi) c <= ci[N-k-1:1];
      end
   end
   assign bus.in_ready  = stg[0].ld;
   assign bus.out_valid = stg[N-1].v;
   assign bus.val_o     = stg[N-1].d[W-1:2];
   assign bus.guard_o   = stg[N-1].d[1];
   assign bus.round_o   = stg[N-1].d[0];
   assign bus.sticky_o  = stg[N-1].s;
   assign bus.tag_o     = stg[N-1].t;
endmodule

// File: doc/fp_rshift_pipe.md
Name: fp_rshift_pipe

Overview:
- Pipelined barrel right shifter that aligns the smaller-exponent mantissa ahead of the FP adder.
- Its counterpart, the combinational left-shift normalizer, sits after the adder.
- One register stage per shift-count bit; produces guard, round and sticky bits for rounding.
- Elastic valid/ready handshake with full backpressure; an opaque tag (sign/exponent) travels alongside each item.

Parameters:
- SHIFTWIDTH, 5, width of shift count; number of pipeline stages.
- DATAWIDTH, 24, mantissa width including hidden bit.
- TAGWIDTH, 9, width of side-band tag carried unchanged with each item.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input item present.
- in_ready  output  1  shifter accepts the item this cycle.
- val  input  DATAWIDTH  mantissa to shift right.
- count  input  SHIFTWIDTH  right-shift amount, 0..2^SHIFTWIDTH-1.
- tag_i  input  TAGWIDTH  side-band data.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- val_o  output  DATAWIDTH  shifted mantissa.
- guard_o  output  1  first bit below val_o LSB.
- round_o  output  1  second bit below val_o LSB.
- sticky_o  output  1  OR of all bits shifted below round position.
- tag_o  output  TAGWIDTH  tag of the item on output.

Behaviour:
- Internal datapath width W = DATAWIDTH+2. The entry word is {val, 2'b00}.
- Stage k (k = 0..SHIFTWIDTH-1) holds: valid_k, data_k[W-1:0], sticky_k, residual count bits, tag_k.
- When count[k]=1, stage k shifts right by 2^k. Zeros fill from the MSB side.
- In stage k, sticky_k = sticky_(k-1) OR (OR of the bits shifted out in this stage). Sticky enters stage 0 as 0.
- A shift of ≥ W clears data and ORs every original 1 bit into sticky. No special case or saturation is needed.
- Outputs come from the last stage:
  - val_o = data[W-1:2], guard_o = data[1], round_o = data[0].
  - sticky_o = sticky, tag_o = tag, out_valid = valid of the last stage.
- Handshake and advance rules:
  - Stage k loads when it is empty or its contents advance this cycle.
  - The last stage advances when out_ready=1.
  - in_ready = stage-0 load condition, computed combinationally from the ready chain.
  - Transfers occur only when valid and ready are both 1 in the same cycle.
  - A stage that is not loading holds data, sticky and tag stable.
  - Output must not change while out_valid=1 and out_ready=0.
- Latency is SHIFTWIDTH cycles from input accept to out_valid, with out_ready held high. Throughput is 1 item/cycle.
- Capacity is SHIFTWIDTH items. Under sustained out_ready=0, in_ready drops after SHIFTWIDTH accepts. No item is lost or duplicated, and order is preserved.
- Simultaneous pop and push when full: both occur, and occupancy is unchanged.
- Reset:
  - Clears all valid bits, data, sticky and tag registers.
  - Outputs after reset: out_valid=0, val_o=0, guard_o=0, round_o=0, sticky_o=0, tag_o=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight item.
  - Inputs presented in the reset cycle are not captured.
- count=0 passes val unchanged, with guard=round=sticky=0.
- Data and tag registers need no reset for function, but are reset so that outputs are deterministic.

Test Plan:
- val=0x800000, count=1, out_ready=1 -> after 5 cycles: val_o=0x400000, g=0, r=0, s=0, tag echoed.
- val=0x800001, count=3 -> val_o=0x100000, g=0, r=0, s=1.
- val=0xC00000, count=24 -> val_o=0, g=1, r=1, s=0. Then val=0xFFFFFF, count=31 -> val_o=0, g=0, r=0, s=1.
- Back-to-back stream of 20 random items, out_ready=1 -> one result per cycle, in order. Every result matches a reference model of ({val,00}>>count) plus sticky.
- Throughput and backpressure:
  - Hold out_ready=0 and push continuously -> in_ready=0 after exactly 5 accepts, and the output stays stable.
  - Toggle out_ready randomly -> all items delivered once, in order.
- Pipeline loaded with 3 items, assert rst for 1 cycle -> next cycle out_valid=0 and all outputs 0, in_ready=1. The items never appear at the output.
